writeback_stage: RTL and testbench

- Final (WB) stage of the 16-bit RISC pipeline; sits directly upstream of the 8x16 register file and drives its write port (flag, destination index, data).
- Accepts one retiring instruction per handshake from the MEM stage and selects the result source: ALU, load data, link (PC+1) or upper immediate.
- Waits for variable-latency load data with a bounded timeout.
- Keeps a retired-instruction counter.

---
 rtl/writeback_stage.sv | 127 ++++++++++++
 tb/tb_writeback_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects the retiring result and drives the register-file write port.
// Loads wait for memory data with a bounded timeout.
module writeback_stage #(
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  inp_clk,
    input  logic                  inp_rst_n,
    input  logic                  inp_valid,
    output logic                  out_ready,
    input  logic                  inp_flush,
    input  logic                  inp_regWriteEn,
    input  logic [REG_ADDR_W-1:0] inp_dest,
    input  logic [1:0]            inp_wbSel,
    input  logic [DATA_W-1:0]     inp_aluResult,
    input  logic [DATA_W-1:0]     inp_pc,
    input  logic [7:0]            inp_imm8,
    input  logic                  inp_memValid,
    input  logic [DATA_W-1:0]     inp_memData,
    output logic                  out_flagWrite,
    output logic [REG_ADDR_W-1:0] out_regWrite,
    output logic [DATA_W-1:0]     out_dataWrite,
    output logic                  out_memTimeout,
    output logic [CNT_W-1:0]      out_retireCount
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmo_q, tmo_d, tmo_inc;
    logic [REG_ADDR_W-1:0] dest_q, wr_dest;
    logic                  we_q;
    logic                  accept, latch, retire, wr_en, abort;
    logic [DATA_W-1:0]     result, wr_data;

    assign out_ready = (state_q == IDLE);
    assign accept    = inp_valid && out_ready && !inp_flush;
    assign tmo_inc   = tmo_q + TW'(1);

    always_comb begin
        result = inp_aluResult;
        unique case (inp_wbSel)
            2'b10:   result = inp_pc + DATA_W'(1);
            2'b11:   result = {inp_imm8, {(DATA_W-8){1'b0}}};
            default: result = inp_aluResult;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        latch   = 1'b0;
        retire  = 1'b0;
        wr_en   = 1'b0;
        abort   = 1'b0;
        wr_dest = dest_q;
        wr_data = result;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    latch = 1'b1;
                    if (inp_wbSel == 2'b01) begin
                        state_d = WAIT_MEM;
                        tmo_d   = '0;
                    end else begin
                        retire  = 1'b1;
                        wr_en   = inp_regWriteEn && (inp_dest != '0);
                        wr_dest = inp_dest;
                    end
                end
            end
            WAIT_MEM: begin
                // flush beats data, data beats timeout
                if (inp_flush) begin
                    state_d = IDLE;
                end else if (inp_memValid) begin
                    state_d = IDLE;
                    retire  = 1'b1;
                    wr_en   = we_q && (dest_q != '0);
                    wr_data = inp_memData;
                end else if (tmo_inc == TMO_MAX) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_q         <= IDLE;
            tmo_q           <= '0;
            dest_q          <= '0;
            we_q            <= 1'b0;
            out_flagWrite   <= 1'b0;
            out_regWrite    <= '0;
            out_dataWrite   <= '0;
            out_memTimeout  <= 1'b0;
            out_retireCount <= '0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            out_flagWrite  <= wr_en;
            out_memTimeout <= abort;
            if (latch) begin
                dest_q <= inp_dest;
                we_q   <= inp_regWriteEn;
            end
            if (wr_en) begin
                out_regWrite  <= wr_dest;
                out_dataWrite <= wr_data;
            end
            if (retire) begin
                out_retireCount <= out_retireCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus load,
// timeout, flush and reset sequences.
module tb_writeback_stage;

    logic        inp_clk = 1'b0;
    logic        inp_rst_n;
    logic        inp_valid;
    logic        out_ready;
    logic        inp_flush;
    logic        inp_regWriteEn;
    logic [2:0]  inp_dest;
    logic [1:0]  inp_wbSel;
    logic [15:0] inp_aluResult;
    logic [15:0] inp_pc;
    logic [7:0]  inp_imm8;
    logic        inp_memValid;
    logic [15:0] inp_memData;
    logic        out_flagWrite;
    logic [2:0]  out_regWrite;
    logic [15:0] out_dataWrite;
    logic        out_memTimeout;
    logic [15:0] out_retireCount;

    int tests = 0;
    int fails = 0;

    writeback_stage dut (
        .inp_clk        (inp_clk),
        .inp_rst_n      (inp_rst_n),
        .inp_valid      (inp_valid),
        .out_ready      (out_ready),
        .inp_flush      (inp_flush),
        .inp_regWriteEn (inp_regWriteEn),
        .inp_dest       (inp_dest),
        .inp_wbSel      (inp_wbSel),
        .inp_aluResult  (inp_aluResult),
        .inp_pc         (inp_pc),
        .inp_imm8       (inp_imm8),
        .inp_memValid   (inp_memValid),
        .inp_memData    (inp_memData),
        .out_flagWrite  (out_flagWrite),
        .out_regWrite   (out_regWrite),
        .out_dataWrite  (out_dataWrite),
        .out_memTimeout (out_memTimeout),
        .out_retireCount(out_retireCount)
    );

    always #5 inp_clk = ~inp_clk;

    typedef struct {
        logic        v, fl, we;
        logic [2:0]  dest;
        logic [1:0]  sel;
        logic [15:0] alu, pc;
        logic [7:0]  imm;
        logic        ef;
        logic [2:0]  er;
        logic [15:0] ed, ec;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge inp_clk);
        #1;
    endtask

    task automatic load(input logic [2:0] d);
        inp_valid      = 1'b1;
        inp_wbSel      = 2'b01;
        inp_dest       = d;
        inp_regWriteEn = 1'b1;
        step();
        inp_valid      = 1'b0;
        inp_memValid   = 1'b0;
    endtask

    task automatic chk_all(input string n, input logic f, input logic [2:0] r,
                           input logic [15:0] d, input logic [15:0] c,
                           input logic rdy, input logic t);
        chk({n, ".flag"}, 32'(out_flagWrite), 32'(f));
        chk({n, ".reg"}, 32'(out_regWrite), 32'(r));
        chk({n, ".data"}, 32'(out_dataWrite), 32'(d));
        chk({n, ".cnt"}, 32'(out_retireCount), 32'(c));
        chk({n, ".ready"}, 32'(out_ready), 32'(rdy));
        chk({n, ".tmo"}, 32'(out_memTimeout), 32'(t));
    endtask

    initial begin
        int k;
        //          v  fl we dest sel    alu       pc        imm    ef er ed        ec
        vt[0] = '{1, 0, 1, 3'd3, 2'b00, 16'h1234, 16'h0000, 8'h00, 1, 3, 16'h1234, 16'd1};
        vt[1] = '{1, 0, 1, 3'd7, 2'b10, 16'h0000, 16'hFFFF, 8'h00, 1, 7, 16'h0000, 16'd2};
        vt[2] = '{1, 0, 1, 3'd2, 2'b11, 16'h0000, 16'h0000, 8'hA5, 1, 2, 16'hA500, 16'd3};
        vt[3] = '{1, 0, 1, 3'd0, 2'b00, 16'h5555, 16'h0000, 8'h00, 0, 2, 16'hA500, 16'd4};
        vt[4] = '{1, 0, 0, 3'd4, 2'b00, 16'h7777, 16'h0000, 8'h00, 0, 2, 16'hA500, 16'd5};
        vt[5] = '{0, 0, 1, 3'd4, 2'b00, 16'h7777, 16'h0000, 8'h00, 0, 2, 16'hA500, 16'd5};
        vt[6] = '{1, 1, 1, 3'd1, 2'b00, 16'h9999, 16'h0000, 8'h00, 0, 2, 16'hA500, 16'd5};
        vt[7] = '{1, 0, 1, 3'd1, 2'b10, 16'h0000, 16'h0010, 8'h00, 1, 1, 16'h0011, 16'd6};
        vt[8] = '{0, 0, 0, 3'd0, 2'b00, 16'h0000, 16'h0000, 8'h00, 0, 1, 16'h0011, 16'd6};

        inp_rst_n = 1'b0; inp_valid = 0; inp_flush = 0; inp_regWriteEn = 0;
        inp_dest = 0; inp_wbSel = 0; inp_aluResult = 0; inp_pc = 0; inp_imm8 = 0;
        inp_memValid = 0; inp_memData = 0;
        #12;
        chk_all("reset", 0, 0, 16'h0, 16'd0, 1, 0);
        @(negedge inp_clk);
        inp_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            inp_valid = vt[i].v; inp_flush = vt[i].fl; inp_regWriteEn = vt[i].we;
            inp_dest = vt[i].dest; inp_wbSel = vt[i].sel; inp_aluResult = vt[i].alu;
            inp_pc = vt[i].pc; inp_imm8 = vt[i].imm;
            step();
            chk_all($sformatf("vec%0d", i), vt[i].ef, vt[i].er, vt[i].ed, vt[i].ec, 1, 0);
        end
        inp_valid = 0; inp_flush = 0;

        // load returning on the 4th cycle; memValid in accept cycle ignored
        inp_memValid = 1'b1; inp_memData = 16'hDEAD;
        load(3'd5);
        chk_all("ld_acc", 0, 1, 16'h0011, 16'd6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("ld_wait%0d", i), 0, 1, 16'h0011, 16'd6, 0, 0);
        end
        inp_memValid = 1'b1; inp_memData = 16'hBEEF;
        step();
        inp_memValid = 1'b0;
        chk_all("ld_done", 1, 5, 16'hBEEF, 16'd7, 1, 0);
        step();
        chk_all("ld_after", 0, 5, 16'hBEEF, 16'd7, 1, 0);

        // timeout: pulse expected exactly 15 cycles after entering WAIT_MEM
        load(3'd6);
        k = 0;
        while (!out_memTimeout && k < 40) begin
            step();
            k++;
            if (out_flagWrite) chk("tmo_nowrite", 32'(out_flagWrite), 0);
        end
        chk("tmo_cycles", 32'(k), 32'd15);
        chk_all("tmo_pulse", 0, 5, 16'hBEEF, 16'd7, 1, 1);
        step();
        chk_all("tmo_after", 0, 5, 16'hBEEF, 16'd7, 1, 0);

        // memValid on the cycle the timeout would fire: data wins
        load(3'd2);
        for (int i = 0; i < 14; i++) step();
        chk("race_ready", 32'(out_ready), 0);
        inp_memValid = 1'b1; inp_memData = 16'h0F0F;
        step();
        inp_memValid = 1'b0;
        chk_all("race", 1, 2, 16'h0F0F, 16'd8, 1, 0);

        // flush coincident with memValid
        load(3'd1);
        step();
        inp_flush = 1'b1; inp_memValid = 1'b1; inp_memData = 16'h1111;
        step();
        inp_flush = 1'b0; inp_memValid = 1'b0;
        chk_all("flush", 0, 2, 16'h0F0F, 16'd8, 1, 0);
        step();
        chk_all("flush_after", 0, 2, 16'h0F0F, 16'd8, 1, 0);

        // async reset in WAIT_MEM, stale memValid afterwards
        load(3'd3);
        step();
        #2 inp_rst_n = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 16'h0, 16'd0, 1, 0);
        @(negedge inp_clk);
        inp_rst_n = 1'b1;
        inp_memValid = 1'b1; inp_memData = 16'h2222;
        step();
        inp_memValid = 1'b0;
        chk_all("rst_stale", 0, 0, 16'h0, 16'd0, 1, 0);
        step();
        chk_all("rst_idle", 0, 0, 16'h0, 16'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
